axis_byte_packer: RTL and testbench

Parametrised AXI4-Stream width upsizer for the Ethernet parsing path: accepts one byte per beat from the byte-wide MAC/parser stream and packs consecutive bytes into OUT_BYTES-wide words with per-byte keep, so downstream header/payload stages can process several bytes per cycle. Frame boundaries (tlast) are preserved; a frame ending mid-word produces a partial word flagged by tkeep. Sustains one input byte per cycle while the output side is ready, with a two-entry (accumulator + output register) buffer absorbing output stalls.

---
 rtl/axis_pkg.sv | 33 +++
 rtl/axis_out_reg.sv | 47 ++++
 rtl/axis_byte_packer.sv | 149 ++++++++++++++
 tb/tb_axis_byte_packer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI4-Stream helpers: FSM state type, lane-index width and keep-mask
// generation, reusable by any byte-lane stream stage.
package axis_pkg;

  // Widest word any stream stage in this path packs, in bytes.
  localparam int MAX_BYTES = 16;

  // Packer accumulator state: FILL collects bytes, HOLD parks a finished word.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pk_state_t;

  // Bits needed to index a lane in an n-byte word (at least one bit).
  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Contiguous keep mask of n_bytes valid lanes in a width-byte word,
  // anchored at lane 0 (little-endian) or at lane width-1 (network order).
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int n_bytes,
                                                     input bit net_order,
                                                     input int width = MAX_BYTES);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (net_order) m[i] = (i < width) && (i >= width - n_bytes);
      else           m[i] = (i < n_bytes);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// AXI4-Stream output register slice: loads a word on request and holds it
// stable until the downstream handshake completes.
module axis_out_reg #(
  parameter int OUT_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [8*OUT_BYTES-1:0] ld_data,
  input  logic [OUT_BYTES-1:0]   ld_keep,
  input  logic                   ld_last,
  output logic [8*OUT_BYTES-1:0] m_axis_tdata,
  output logic [OUT_BYTES-1:0]   m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready
);

  logic [8*OUT_BYTES-1:0] data_p1;
  logic [OUT_BYTES-1:0]   keep_p1;
  logic                   last_p1;
  logic                   vld_p1;

  // Output stage: load replaces the word (also on a same-edge handshake);
  // otherwise valid clears only when the word is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (load) begin
      data_p1 <= ld_data;
      keep_p1 <= ld_keep;
      last_p1 <= ld_last;
      vld_p1  <= 1'b1;
    end else if (m_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m_axis_tdata  = data_p1;
  assign m_axis_tkeep  = keep_p1;
  assign m_axis_tlast  = last_p1;
  assign m_axis_tvalid = vld_p1;

endmodule

// File: rtl/axis_byte_packer.sv
// Byte-to-word AXI4-Stream upsizer: packs consecutive bytes into OUT_BYTES-wide
// words with per-byte keep, preserving frame boundaries.
// Optional macro AXIS_PACKER_NET_ORDER_EN: first byte of each word lands in the
// most significant lane; default places it in lane 0.
module axis_byte_packer
  import axis_pkg::*;
#(
  parameter int OUT_BYTES = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [8*OUT_BYTES-1:0] m_axis_tdata,
  output logic [OUT_BYTES-1:0]   m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [CNT_WIDTH-1:0]   frame_count
);

  localparam int LANE_W = lane_w(OUT_BYTES);
  localparam int DW     = 8 * OUT_BYTES;
`ifdef AXIS_PACKER_NET_ORDER_EN
  localparam bit NET_ORDER = 1'b1;
`else
  localparam bit NET_ORDER = 1'b0;
`endif

  pk_state_t             state, state_nxt;
  logic [LANE_W-1:0]     lane;
  logic [LANE_W-1:0]     phys;
  logic [DW-1:0]         acc_data_p0;
  logic [OUT_BYTES-1:0]  acc_keep_p0;
  logic                  acc_last_p0;
  logic                  s_ready_q;
  logic                  take, complete, slot_free;
  logic                  load, hold_word, clr_acc;
  logic [DW-1:0]         w_data, ld_data;
  logic [OUT_BYTES-1:0]  w_keep, ld_keep;
  logic                  ld_last;

  // Input stage: merge the incoming byte into the accumulator image.
  assign phys      = NET_ORDER ? (LANE_W'(OUT_BYTES - 1) - lane) : lane;
  assign w_data    = acc_data_p0 | (DW'(s_axis_tdata) << {phys, 3'b000});
  assign w_keep    = OUT_BYTES'(keep_mask(int'(lane) + 1, NET_ORDER, OUT_BYTES));
  assign take      = s_axis_tvalid && s_ready_q;
  assign complete  = take && ((lane == LANE_W'(OUT_BYTES - 1)) || s_axis_tlast);
  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = s_ready_q;

  // Next state and word routing: finished words go straight to the output
  // register when its slot frees this cycle, otherwise park in the accumulator.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    hold_word = 1'b0;
    clr_acc   = 1'b0;
    ld_data   = w_data;
    ld_keep   = w_keep;
    ld_last   = s_axis_tlast;
    case (state)
      FILL: begin
        if (complete) begin
          if (slot_free) begin
            load    = 1'b1;
            clr_acc = 1'b1;
          end else begin
            hold_word = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        ld_data = acc_data_p0;
        ld_keep = acc_keep_p0;
        ld_last = acc_last_p0;
        if (slot_free) begin
          load      = 1'b1;
          clr_acc   = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // State register; input ready is registered so it never depends on m_axis_tready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      s_ready_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_ready_q <= (state_nxt == FILL);
    end
  end

  // Accumulator: clear on hand-off so lanes past a short frame read as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane        <= '0;
      acc_data_p0 <= '0;
      acc_keep_p0 <= '0;
      acc_last_p0 <= 1'b0;
    end else begin
      if (clr_acc) begin
        acc_data_p0 <= '0;
        acc_keep_p0 <= '0;
        acc_last_p0 <= 1'b0;
      end else if (hold_word || take) begin
        acc_data_p0 <= w_data;
        acc_keep_p0 <= w_keep;
        acc_last_p0 <= s_axis_tlast;
      end
      if (complete)  lane <= '0;
      else if (take) lane <= lane + LANE_W'(1);
    end
  end

  // Output stage boundary.
  axis_out_reg #(
    .OUT_BYTES(OUT_BYTES)
  ) u_out_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .ld_data      (ld_data),
    .ld_keep      (ld_keep),
    .ld_last      (ld_last),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  // Completed-frame counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n)
      frame_count <= '0;
    else if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
      frame_count <= frame_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Bench for axis_byte_packer (OUT_BYTES=4): table vectors, stall/reset
// sequences and randomized frames against a frame-level packing model.
module tb_axis_byte_packer;

  localparam int OB = 4;
`ifdef AXIS_PACKER_NET_ORDER_EN
  localparam bit NET = 1'b1;
`else
  localparam bit NET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid, m_last, m_ready;
  logic [15:0] fc;

  axis_byte_packer #(.OUT_BYTES(OB), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_data),
    .s_axis_tvalid(s_valid),
    .s_axis_tlast (s_last),
    .s_axis_tready(s_ready),
    .m_axis_tdata (m_data),
    .m_axis_tkeep (m_keep),
    .m_axis_tvalid(m_valid),
    .m_axis_tlast (m_last),
    .m_axis_tready(m_ready),
    .frame_count  (fc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  typedef struct packed {
    int               len;
    logic [5:0][7:0]  b;
    int               nw;
    logic [1:0][31:0] d;
    logic [1:0][3:0]  k;
    logic [1:0]       l;
  } vec_t;

  word_t      expq[$];
  logic [7:0] cur_frame[$];
  int         checks = 0;
  int         errors = 0;
  int         frames_exp = 0;
  int         rdy_mode = 1;
  bit         rand_idle = 0;
  bit         mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Frame-level reference: chop the byte list into OB-byte words.
  task automatic model_frame();
    int n;
    n = cur_frame.size();
    for (int w = 0; w * OB < n; w++) begin
      word_t x;
      x = '0;
      for (int k = 0; k < OB; k++) begin
        int idx;
        int pos;
        idx = w * OB + k;
        pos = NET ? (OB - 1 - k) : k;
        if (idx < n) begin
          x.data[8*pos +: 8] = cur_frame[idx];
          x.keep[pos] = 1'b1;
        end
      end
      x.last = ((w + 1) * OB >= n);
      expq.push_back(x);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    if (rand_idle)
      while ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    s_data = b; s_last = l; s_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 500) begin
        chk("send_timeout", 64'd1, 64'd0);
        finish_sim();
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < cur_frame.size(); i++)
      send_byte(cur_frame[i], i == cur_frame.size() - 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || m_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(expq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Downstream ready generator.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Output monitor: scoreboard on handshakes, stability while stalled.
  logic        stall_prev = 1'b0;
  logic [31:0] pd;
  logic [3:0]  pk;
  logic        pl;
  always @(negedge clk) begin
    if (!mon_en) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stable", {m_valid, m_last, m_keep, m_data}, {1'b1, pl, pk, pd});
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", {m_last, m_keep, m_data}, 64'd0);
        end else begin
          word_t e;
          e = expq.pop_front();
          chk("word", {m_last, m_keep, m_data}, {e.last, e.keep, e.data});
        end
      end
      stall_prev = m_valid && !m_ready;
      pd = m_data; pk = m_keep; pl = m_last;
    end
  end

  vec_t vt[3];

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;

    vt[0] = '0; vt[0].len = 4; vt[0].nw = 1;
    vt[0].b[0] = 8'h11; vt[0].b[1] = 8'h22; vt[0].b[2] = 8'h33; vt[0].b[3] = 8'h44;
    vt[1] = '0; vt[1].len = 6; vt[1].nw = 2;
    for (int i = 0; i < 6; i++) vt[1].b[i] = 8'(i + 1);
    vt[2] = '0; vt[2].len = 1; vt[2].nw = 1; vt[2].b[0] = 8'hAB;
`ifdef AXIS_PACKER_NET_ORDER_EN
    vt[0].d[0] = 32'h11223344; vt[0].k[0] = 4'hF; vt[0].l[0] = 1'b1;
    vt[1].d[0] = 32'h01020304; vt[1].k[0] = 4'hF; vt[1].l[0] = 1'b0;
    vt[1].d[1] = 32'h05060000; vt[1].k[1] = 4'hC; vt[1].l[1] = 1'b1;
    vt[2].d[0] = 32'hAB000000; vt[2].k[0] = 4'h8; vt[2].l[0] = 1'b1;
`else
    vt[0].d[0] = 32'h44332211; vt[0].k[0] = 4'hF; vt[0].l[0] = 1'b1;
    vt[1].d[0] = 32'h04030201; vt[1].k[0] = 4'hF; vt[1].l[0] = 1'b0;
    vt[1].d[1] = 32'h00000605; vt[1].k[1] = 4'h3; vt[1].l[1] = 1'b1;
    vt[2].d[0] = 32'h000000AB; vt[2].k[0] = 4'h1; vt[2].l[0] = 1'b1;
`endif

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {m_valid, m_last, m_keep, m_data}, 64'd0);
    chk("rst_tready", 64'(s_ready), 64'd0);
    chk("rst_count", 64'(fc), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("tready_after_rst", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Table vectors, ready held high
    for (int e = 0; e < 3; e++) begin
      for (int j = 0; j < vt[e].nw; j++)
        expq.push_back('{data: vt[e].d[j], keep: vt[e].k[j], last: vt[e].l[j]});
      for (int i = 0; i < vt[e].len; i++)
        send_byte(vt[e].b[i], i == vt[e].len - 1);
      @(negedge clk);
      chk("latency_last", {62'd0, m_valid, m_last}, 64'd3);
      drain();
      frames_exp++;
      chk("count_table", 64'(fc), 64'(frames_exp));
    end

    // Output stalled while 12 bytes stream in
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    cur_frame.delete();
    for (int i = 0; i < 12; i++) cur_frame.push_back(8'(8'h20 + i));
    model_frame();
    for (int i = 0; i < 8; i++) send_byte(cur_frame[i], 1'b0);
    @(negedge clk);
    chk("bp_tready_low", 64'(s_ready), 64'd0);
    chk("bp_word1_held", {m_valid, m_data}, {1'b1, expq[0].data});
    repeat (5) @(posedge clk); #1;
    rdy_mode = 1;
    for (int i = 8; i < 12; i++) send_byte(cur_frame[i], i == 11);
    drain();
    frames_exp++;
    chk("count_bp", 64'(fc), 64'(frames_exp));

    // Random frames under random backpressure
    rand_idle = 1'b1;
    rdy_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      int len;
      len = $urandom_range(1, 64);
      cur_frame.delete();
      for (int i = 0; i < len; i++) cur_frame.push_back(8'($urandom));
      model_frame();
      send_frame();
      frames_exp++;
    end
    rand_idle = 1'b0;
    rdy_mode = 1;
    drain();
    chk("count_random", 64'(fc), 64'(16'(frames_exp)));

    // One-cycle reset mid-word with a held output word
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    mon_en = 1'b0;
    expq.delete();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h60 + i), 1'b0);
    @(negedge clk);
    chk("pre_rst_held", 64'(m_valid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {m_valid, m_last, m_keep, m_data}, 64'd0);
    chk("midrst_count", 64'(fc), 64'd0);
    @(negedge clk);
    chk("midrst_tready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    rdy_mode = 1;
    frames_exp = 0;
    mon_en = 1'b1;
    cur_frame.delete();
    cur_frame.push_back(8'hA1); cur_frame.push_back(8'hA2); cur_frame.push_back(8'hA3);
    model_frame();
    send_frame();
    drain();
    frames_exp++;
    chk("count_after_rst", 64'(fc), 64'(frames_exp));

    finish_sim();
  end

  // Global watchdog.
  initial begin
    #900000;
    chk("watchdog", 64'd1, 64'd0);
    finish_sim();
  end

endmodule
